sorted_match_serializer: RTL and testbench

- Sits directly downstream of the bitonic merge network in the packet classification pipeline.
- Takes each sorted N-entry rule-ID vector from the merge output and emits the matching IDs one per beat, lowest (highest-priority) first, over a valid/ready stream.
- Skips the all-ones "no match" sentinel entries.
- Holds one active vector plus one pending vector, so a new merge result can be accepted while the previous one is still draining.

---
 rtl/sorted_match_serializer.sv | 139 +++++++++++++
 tb/tb_sorted_match_serializer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sorted_match_serializer.sv
// Serialises sorted rule-ID vectors from the merge network into one ID per beat,
// lowest first, with one active and one pending vector slot.
module sorted_match_serializer #(
    parameter int N             = 16,
    parameter int log_N         = 4,
    parameter int INPUT_WIDTH   = 4,
    parameter int SKIP_SENTINEL = 1
) (
    input  logic                       clk,
    input  logic                       sync,
    input  logic                       in_valid,
    input  logic [0:INPUT_WIDTH*N-1]   in,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INPUT_WIDTH-1:0]     out_data,
    output logic                       out_last,
    output logic                       out_nomatch,
    output logic                       overflow
);

    typedef enum logic [1:0] {
        S_EMPTY       = 2'd0,
        S_ACTIVE      = 2'd1,
        S_ACTIVE_PEND = 2'd2
    } state_t;

    localparam logic [INPUT_WIDTH-1:0] SENTINEL = '1;
    localparam logic [log_N-1:0]       LAST_IDX = log_N'(N - 1);

    state_t                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] active_q  [N];
    logic [INPUT_WIDTH-1:0] active_d  [N];
    logic [INPUT_WIDTH-1:0] pending_q [N];
    logic [INPUT_WIDTH-1:0] pending_d [N];
    logic [log_N-1:0]       index_q, index_d;
    logic                   overflow_q, overflow_d;

    logic [INPUT_WIDTH-1:0] in_entry [N];
    logic [INPUT_WIDTH-1:0] cur_entry;
    logic [log_N-1:0]       next_idx;
    logic                   at_end;
    logic                   nomatch_raw;
    logic                   last_raw;
    logic                   accept;
    logic                   fire;
    logic                   done;

    // Entry 0 occupies the leftmost bits of the ascending-range input bus.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign in_entry[gi] = in[gi*INPUT_WIDTH +: INPUT_WIDTH];
        end
    endgenerate

    assign cur_entry   = active_q[index_q];
    assign next_idx    = index_q + log_N'(1);
    assign at_end      = (index_q == LAST_IDX);
    // A sorted vector that starts with the sentinel holds no matches at all.
    assign nomatch_raw = (SKIP_SENTINEL != 0) && (index_q == '0) && (cur_entry == SENTINEL);
    assign last_raw    = at_end || nomatch_raw ||
                         ((SKIP_SENTINEL != 0) && (active_q[next_idx] == SENTINEL));

    assign accept = in_valid && in_ready;
    assign fire   = out_valid && out_ready;
    assign done   = fire && out_last;

    always_ff @(posedge clk) begin
        if (sync) begin
            state_q    <= S_EMPTY;
            index_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                active_q[i]  <= '0;
                pending_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            overflow_q <= overflow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        active_d   = active_q;
        pending_d  = pending_q;
        overflow_d = overflow_q | (in_valid & ~in_ready);
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    active_d = in_entry;
                    index_d  = '0;
                    state_d  = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (done) begin
                    // A vector arriving as the last beat leaves goes straight to active.
                    if (accept) begin
                        active_d = in_entry;
                        index_d  = '0;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end else begin
                    if (fire) index_d = next_idx;
                    if (accept) begin
                        pending_d = in_entry;
                        state_d   = S_ACTIVE_PEND;
                    end
                end
            end
            S_ACTIVE_PEND: begin
                if (done) begin
                    active_d = pending_q;
                    index_d  = '0;
                    state_d  = S_ACTIVE;
                end else if (fire) begin
                    index_d = next_idx;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        out_valid   = (state_q != S_EMPTY);
        in_ready    = (state_q != S_ACTIVE_PEND);
        out_data    = out_valid ? cur_entry : '0;
        out_last    = out_valid && last_raw;
        out_nomatch = out_valid && nomatch_raw;
        overflow    = overflow_q;
    end

endmodule

// File: tb/tb_sorted_match_serializer.sv
// Directed bench for sorted_match_serializer: a sentinel-skipping instance and a
// raw (SKIP_SENTINEL=0) instance share one stimulus stream.
module tb_sorted_match_serializer;

    localparam int N = 16;
    localparam int W = 4;

    logic             clk = 1'b0;
    logic             sync;
    logic             in_valid;
    logic [0:W*N-1]   in_vec;
    logic             out_ready;

    logic             in_ready, out_valid, out_last, out_nomatch, overflow;
    logic [W-1:0]     out_data;
    logic             r_in_ready, r_out_valid, r_out_last, r_out_nomatch, r_overflow;
    logic [W-1:0]     r_out_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sorted_match_serializer #(.N(N), .log_N(4), .INPUT_WIDTH(W), .SKIP_SENTINEL(1)) u_dut (
        .clk(clk), .sync(sync), .in_valid(in_valid), .in(in_vec), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_nomatch(out_nomatch), .overflow(overflow)
    );

    sorted_match_serializer #(.N(N), .log_N(4), .INPUT_WIDTH(W), .SKIP_SENTINEL(0)) u_raw (
        .clk(clk), .sync(sync), .in_valid(in_valid), .in(in_vec), .in_ready(r_in_ready),
        .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
        .out_last(r_out_last), .out_nomatch(r_out_nomatch), .overflow(r_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic expect_beat(input string tag, input int data, input bit last, input bit nm);
        check({tag, ".valid"},   32'(out_valid),   32'd1);
        check({tag, ".data"},    32'(out_data),    32'(data));
        check({tag, ".last"},    32'(out_last),    32'(last));
        check({tag, ".nomatch"}, 32'(out_nomatch), 32'(nm));
    endtask

    // Up to three leading entries; the rest are the sentinel.
    function automatic logic [0:W*N-1] mkvec(input int n, input int e0, input int e1, input int e2);
        logic [0:W*N-1] v;
        int e [3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        v = '1;
        for (int i = 0; i < n; i++) v[i*W +: W] = W'(e[i]);
        return v;
    endfunction

    task automatic send(input logic [0:W*N-1] v);
        in_vec   = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        sync = 1'b1;
        repeat (2) @(negedge clk);
        sync = 1'b0;
    endtask

    logic [0:W*N-1] ramp;

    initial begin
        sync = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
        @(negedge clk);

        // Reset then idle
        do_reset();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.overflow",  32'(overflow),  32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.out_data",  32'(out_data),  32'd0);
        check("rst.out_last",  32'(out_last),  32'd0);

        // Partial vector {2,5,9,F..}
        send(mkvec(3, 2, 5, 9));
        expect_beat("part.b0", 2, 0, 0);
        @(negedge clk); expect_beat("part.b1", 5, 0, 0);
        @(negedge clk); expect_beat("part.b2", 9, 1, 0);
        @(negedge clk); check("part.idle", 32'(out_valid), 32'd0);

        // Stall hold on beat 5
        send(mkvec(3, 2, 5, 9));
        expect_beat("stall.b0", 2, 0, 0);
        @(negedge clk); expect_beat("stall.b1", 5, 0, 0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); expect_beat($sformatf("stall.hold%0d", k), 5, 0, 0);
        end
        out_ready = 1'b1;
        @(negedge clk); expect_beat("stall.b2", 9, 1, 0);
        @(negedge clk); check("stall.idle", 32'(out_valid), 32'd0);

        // All-sentinel vector
        send(mkvec(0, 0, 0, 0));
        expect_beat("empty.b0", 15, 1, 1);
        @(negedge clk); check("empty.idle", 32'(out_valid), 32'd0);

        // Full ramp 0..F: raw instance emits 16 beats; skipping one stops at 14
        do_reset();
        for (int i = 0; i < N; i++) ramp[i*W +: W] = W'(i);
        send(ramp);
        for (int k = 0; k < N; k++) begin
            check($sformatf("raw.b%0d.valid", k), 32'(r_out_valid), 32'd1);
            check($sformatf("raw.b%0d.data", k),  32'(r_out_data),  32'(k));
            check($sformatf("raw.b%0d.last", k),  32'(r_out_last),  32'(k == 15));
            if (k < 15) begin
                check($sformatf("skip.b%0d.data", k), 32'(out_data), 32'(k));
                check($sformatf("skip.b%0d.last", k), 32'(out_last), 32'(k == 14));
            end else begin
                check("skip.idle", 32'(out_valid), 32'd0);
            end
            @(negedge clk);
        end
        check("raw.idle", 32'(r_out_valid), 32'd0);

        // Back-to-back A={1,3} B={4}
        do_reset();
        in_vec = mkvec(2, 1, 3, 0); in_valid = 1'b1;
        @(negedge clk);
        in_vec = mkvec(1, 4, 0, 0); in_valid = 1'b1;
        check("b2b.ready_a", 32'(in_ready), 32'd1);
        expect_beat("b2b.b0", 1, 0, 0);
        @(negedge clk); in_valid = 1'b0;
        expect_beat("b2b.b1", 3, 1, 0);
        check("b2b.ready_pend", 32'(in_ready), 32'd0);
        @(negedge clk); expect_beat("b2b.b2", 4, 1, 0);
        check("b2b.ready_after", 32'(in_ready), 32'd1);
        @(negedge clk); check("b2b.idle", 32'(out_valid), 32'd0);

        // Overflow: third vector while pending is full
        do_reset();
        out_ready = 1'b0;
        in_vec = mkvec(2, 1, 3, 0); in_valid = 1'b1;
        @(negedge clk);
        in_vec = mkvec(1, 4, 0, 0);
        @(negedge clk);
        check("ovf.ready", 32'(in_ready), 32'd0);
        check("ovf.before", 32'(overflow), 32'd0);
        in_vec = mkvec(1, 7, 0, 0);
        @(negedge clk); in_valid = 1'b0;
        check("ovf.set", 32'(overflow), 32'd1);
        expect_beat("ovf.hold", 1, 0, 0);
        out_ready = 1'b1;
        @(negedge clk); expect_beat("ovf.b1", 3, 1, 0);
        @(negedge clk); expect_beat("ovf.b2", 4, 1, 0);
        @(negedge clk); check("ovf.dropped", 32'(out_valid), 32'd0);
        check("ovf.sticky", 32'(overflow), 32'd1);

        // Reset mid-drain
        send(mkvec(3, 2, 5, 9));
        expect_beat("mid.b0", 2, 0, 0);
        sync = 1'b1;
        @(negedge clk); sync = 1'b0;
        check("mid.out_valid", 32'(out_valid), 32'd0);
        check("mid.overflow",  32'(overflow),  32'd0);
        check("mid.in_ready",  32'(in_ready),  32'd1);
        @(negedge clk); check("mid.discarded", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
